// File: rtl/serial_add_pkg.sv
// ============================================================================
//  Module      : serial_add_pkg
//  Description : Shared state encoding and counter-width helper for the
//                bit-serial addition controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter must hold 0..WIDTH without wrapping.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/FA.sv
// ============================================================================
//  Module      : FA
//  Description : Single-bit full-adder cell with propagate output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module FA (
    input  logic a,
    input  logic b,
    input  logic Cin,
    output logic Cout,
    output logic P,
    output logic S
);

    assign P    = a ^ b;
    assign S    = P ^ Cin;
    assign Cout = (a & b) | (P & Cin);

endmodule

`default_nettype wire

// File: rtl/serial_add_ctrl.sv
// ============================================================================
//  Module      : serial_add_ctrl
//  Description : Bit-serial adder controller time-sharing one FA cell, LSB
//                first. Optional subtract mode under macro SERIAL_SUB_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             p_all
);

    localparam int                c_cnt_w = cnt_width(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_carry;
    logic               r_pacc;
    logic               w_accept;
    logic               w_last;
    logic               w_b_fa;
    logic               w_cout;
    logic               w_p;
    logic               w_s;
    logic [WIDTH-1:0]   w_result;

    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last   = (r_state == RUN) && (r_cnt == c_last);

    assign ready = (r_state == IDLE) || (r_state == DONE);
    assign busy  = (r_state == RUN);
    assign done  = (r_state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (r_cnt == c_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = start ? RUN : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef SERIAL_SUB_EN
    logic r_sub;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_sub <= 1'b0;
        else if (w_accept) r_sub <= sub;
    end

    // Subtract is A + ~B + 1; the +1 comes in as the initial carry.
    assign w_b_fa = r_b_sh[0] ^ r_sub;

    function automatic logic init_carry(input logic s, input logic c);
        return s ? 1'b1 : c;
    endfunction
`else
    assign w_b_fa = r_b_sh[0];

    function automatic logic init_carry(input logic s, input logic c);
        return s | c;
    endfunction
`endif

    FA u_fa (
        .a    (r_a_sh[0]),
        .b    (w_b_fa),
        .Cin  (r_carry),
        .Cout (w_cout),
        .P    (w_p),
        .S    (w_s)
    );

    // Only WIDTH-1 sum bits need storing; the final bit is taken straight
    // from the cell on the completing edge.
    generate
        if (WIDTH == 1) begin : g_work_w1
            assign w_result = w_s;
        end else begin : g_work_wn
            logic [WIDTH-2:0] r_work;

            assign w_result = {w_s, r_work};

            always_ff @(posedge clk or posedge rst) begin
                if (rst)                  r_work <= '0;
                else if (r_state == RUN)  r_work <= w_result[WIDTH-1:1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_pacc  <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            p_all   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a_sh  <= a_in;
                r_b_sh  <= b_in;
                r_cnt   <= '0;
`ifdef SERIAL_SUB_EN
                r_carry <= init_carry(sub, cin_in);
`else
                r_carry <= init_carry(1'b0, cin_in);
`endif
                r_pacc  <= 1'b1;
            end else if (r_state == RUN) begin
                r_a_sh  <= r_a_sh >> 1;
                r_b_sh  <= r_b_sh >> 1;
                r_cnt   <= r_cnt + c_one;
                r_carry <= w_cout;
                r_pacc  <= r_pacc & w_p;
            end
            if (w_last) begin
                sum   <= w_result;
                cout  <= w_cout;
                p_all <= r_pacc & w_p;
            end
        end
    end

endmodule

`default_nettype wire
